encoder_8_3: RTL and testbench

- Sequential 8-to-3 priority encoder; the inverse of the 3-to-8 decoder.
- Takes 8 asynchronous request lines (board switches or keys), synchronizes them and filters them for stability.
- Outputs the index of the highest set bit, a valid flag and a one-cycle change pulse.
- Sits between raw board inputs and downstream logic, e.g. feeding decoder in_1..in_3 for a loop-back demo.

---
 rtl/encoder_8_3_pkg.sv | 28 ++
 rtl/encoder_8_3_input_filter.sv | 85 ++++++++
 rtl/encoder_8_3.sv | 120 ++++++++++++
 tb/tb_encoder_8_3.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/encoder_8_3_pkg.sv
// -----------------------------------------------------------------------------
// encoder_8_3_pkg
//
// Purpose : shared definitions for the 8-to-3 priority encoder slice
//           (encoder_8_3 top and its input_filter sub-module). Holds the
//           code/input widths, default stability-window parameters and the
//           packed type used for the registered output code.
//
// Contents:
//   ENC_CODE_W      width of the encoded index (3)
//   ENC_IN_W        number of request lines (8)
//   ENC_CNT_MAX_DEF default stability window, 20 ms at 50 MHz
//   ENC_CNT_W_DEF   default stability counter width
//   enc_code_t      {valid, idx} pair as presented on the outputs
// -----------------------------------------------------------------------------
package encoder_8_3_pkg;

    localparam int unsigned ENC_CODE_W      = 3;
    localparam int unsigned ENC_IN_W        = 8;
    localparam int unsigned ENC_CNT_MAX_DEF = 999_999;
    localparam int unsigned ENC_CNT_W_DEF   = 20;

    typedef struct packed {
        logic                  valid;
        logic [ENC_CODE_W-1:0] idx;
    } enc_code_t;

endpackage : encoder_8_3_pkg

// File: rtl/encoder_8_3_input_filter.sv
// -----------------------------------------------------------------------------
// input_filter
//
// Purpose : brings 8 asynchronous request lines into the sys_clk domain and
//           only passes a new value on once it has been stable for CNT_MAX+1
//           consecutive synchronized samples (switch/key debounce).
//
// Parameters:
//   CNT_MAX  stable cycles required before a value is accepted
//   CNT_W    stability counter width, 2**CNT_W > CNT_MAX
//
// Ports:
//   sys_clk    in   system clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   in[7:0]    in   raw asynchronous request lines
//   flt[7:0]   out  filtered (accepted) request vector
// -----------------------------------------------------------------------------
module input_filter
    import encoder_8_3_pkg::*;
#(
    parameter int unsigned CNT_MAX = ENC_CNT_MAX_DEF,
    parameter int unsigned CNT_W   = ENC_CNT_W_DEF
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [ENC_IN_W-1:0] in,
    output logic [ENC_IN_W-1:0] flt
);

    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CNT_MAX);
    // Loading one count before saturation gives exactly one load per stable
    // episode: once cnt sits at CNT_TOP the load condition can never recur.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CNT_MAX - 1);

    // in_d1/in_d2 are the metastability pair; in_d3 is a delayed copy of
    // in_d2 used only to detect a change between consecutive samples.
    logic [ENC_IN_W-1:0] in_d1_q;
    logic [ENC_IN_W-1:0] in_d2_q;
    logic [ENC_IN_W-1:0] in_d3_q;

    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [ENC_IN_W-1:0] flt_q;
    logic [ENC_IN_W-1:0] flt_d;
    logic                stable;

    assign stable = (in_d2_q == in_d3_q);

    // Stability counter: restart on any change, otherwise count up and
    // saturate at CNT_TOP so a long steady input never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (!stable) begin
            cnt_d = '0;
        end else if (cnt_q < CNT_TOP) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        flt_d = flt_q;
        if (stable && (cnt_q == CNT_LOAD)) begin
            flt_d = in_d2_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            in_d1_q <= '0;
            in_d2_q <= '0;
            in_d3_q <= '0;
            cnt_q   <= '0;
            flt_q   <= '0;
        end else begin
            in_d1_q <= in;
            in_d2_q <= in_d1_q;
            in_d3_q <= in_d2_q;
            cnt_q   <= cnt_d;
            flt_q   <= flt_d;
        end
    end

    assign flt = flt_q;

endmodule : input_filter

// File: rtl/encoder_8_3.sv
// -----------------------------------------------------------------------------
// encoder_8_3
//
// Purpose : sequential 8-to-3 priority encoder for board switches/keys.
//           Requests are synchronized and debounced by input_filter, then the
//           index of the highest set bit is registered together with a valid
//           flag and a one-cycle change pulse.
//
// Parameters:
//   CNT_MAX  stable cycles required before a new input is accepted
//   CNT_W    stability counter width, 2**CNT_W > CNT_MAX
//
// Ports:
//   sys_clk    in   system clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   in[7:0]    in   asynchronous request lines, in[7] highest priority
//   out[2:0]   out  index of highest set filtered bit, 0 when none set
//   valid      out  filtered input is non-zero
//   err        out  (only with ENCODER_MULTI_CHK_EN) two or more bits set
//   chg        out  one-cycle pulse when the registered outputs change
//
// Build option:
//   ENCODER_MULTI_CHK_EN  adds the err output; chg then also reacts to err.
// -----------------------------------------------------------------------------
module encoder_8_3
    import encoder_8_3_pkg::*;
#(
    parameter int unsigned CNT_MAX = ENC_CNT_MAX_DEF,
    parameter int unsigned CNT_W   = ENC_CNT_W_DEF
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [ENC_IN_W-1:0]   in,
    output logic [ENC_CODE_W-1:0] out,
    output logic                  valid,
`ifdef ENCODER_MULTI_CHK_EN
    output logic                  err,
`endif
    output logic                  chg
);

    logic [ENC_IN_W-1:0] flt;

    input_filter #(
        .CNT_MAX (CNT_MAX),
        .CNT_W   (CNT_W)
    ) u_input_filter (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in        (in),
        .flt       (flt)
    );

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    function automatic logic [ENC_CODE_W-1:0] prio_idx(input logic [ENC_IN_W-1:0] v);
        logic [ENC_CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(ENC_IN_W); i++) begin
            if (v[i]) begin
                idx = ENC_CODE_W'(i);
            end
        end
        return idx;
    endfunction

`ifdef ENCODER_MULTI_CHK_EN
    // Clearing the lowest set bit leaves something only if 2+ bits were set.
    function automatic logic multi_hot(input logic [ENC_IN_W-1:0] v);
        return (v & (v - ENC_IN_W'(1))) != '0;
    endfunction
`endif

    enc_code_t code_q;
    enc_code_t code_d;
    logic      chg_q;
    logic      chg_d;

`ifdef ENCODER_MULTI_CHK_EN
    logic      err_q;
    logic      err_d;

    always_comb begin
        code_d.valid = |flt;
        code_d.idx   = prio_idx(flt);
        err_d        = multi_hot(flt);
        chg_d        = (code_d != code_q) || (err_d != err_q);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    always_comb begin
        code_d.valid = |flt;
        code_d.idx   = prio_idx(flt);
        chg_d        = (code_d != code_q);
    end
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            code_q <= '0;
            chg_q  <= 1'b0;
        end else begin
            code_q <= code_d;
            chg_q  <= chg_d;
        end
    end

    assign out   = code_q.idx;
    assign valid = code_q.valid;
    assign chg   = chg_q;

endmodule : encoder_8_3

// File: tb/tb_encoder_8_3.sv
// -----------------------------------------------------------------------------
// tb_encoder_8_3
//
// Scoreboard bench for encoder_8_3 with CNT_MAX=4. A reference model tracks
// the synchronized input as a sample stream: a value is accepted once it has
// been seen CNT_MAX+1 times in a row, and the outputs follow one edge later.
// Every expected output change is queued; a monitor on the falling edge pops
// an entry whenever the DUT pulses chg and also checks the output levels.
// -----------------------------------------------------------------------------
module tb_encoder_8_3;

    localparam int CNT_MAX = 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [7:0] in;
    logic [2:0] out;
    logic       valid;
    logic       chg;
`ifdef ENCODER_MULTI_CHK_EN
    logic       err;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        logic [4:0] code;   // {err, valid, out}
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] level_m;
    logic [7:0] flt_m;
    logic [7:0] samp[$];
    logic [7:0] prev_v;
    int         run;

    encoder_8_3 #(
        .CNT_MAX (CNT_MAX),
        .CNT_W   (20)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in        (in),
        .out       (out),
        .valid     (valid),
`ifdef ENCODER_MULTI_CHK_EN
        .err       (err),
`endif
        .chg       (chg)
    );

    always #5 sys_clk = ~sys_clk;

    // Expected {err, valid, out} for an accepted input vector.
    function automatic logic [4:0] ref_code(input logic [7:0] v);
        int   hi;
        logic e;
        hi = -1;
        for (int i = 7; i >= 0; i--) begin
            if (v[i] && hi < 0) hi = i;
        end
`ifdef ENCODER_MULTI_CHK_EN
        e = ($countones(v) >= 2);
`else
        e = 1'b0;
`endif
        return {e, (hi >= 0), (hi >= 0) ? 3'(hi) : 3'd0};
    endfunction

    function automatic logic [4:0] dut_code();
`ifdef ENCODER_MULTI_CHK_EN
        return {err, valid, out};
`else
        return {1'b0, valid, out};
`endif
    endfunction

    task automatic model_reset();
        flt_m   = 8'h00;
        level_m = 5'd0;
        sb.delete();
        samp    = '{8'h00, 8'h00};
        prev_v  = 8'h00;
        run     = 0;
    endtask

    // Reference model
    initial begin
        logic [4:0] nxt;
        logic [7:0] v;
        model_reset();
        forever begin
            @(posedge sys_clk or negedge sys_rst_n);
            if (sys_clk) cyc++;
            if (!sys_rst_n) begin
                model_reset();
            end else begin
                nxt = ref_code(flt_m);
                if (nxt != level_m) sb.push_back('{code: nxt, cyc: cyc});
                level_m = nxt;
                samp.push_back(in);
                v = samp.pop_front();
                if (v == prev_v) run++;
                else run = 1;
                prev_v = v;
                if (run == CNT_MAX + 1) flt_m = v;
            end
        end
    end

    // Monitor
    initial begin
        logic [4:0] got;
        exp_t       e;
        forever begin
            @(negedge sys_clk);
            got = dut_code();
            vectors++;
            if (got !== level_m) begin
                miscompares++;
                $display("FAIL level cyc=%0d got={err,valid,out}=%b want=%b", cyc, got, level_m);
            end
            if (chg === 1'b1) begin
                vectors++;
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    miscompares++;
                    $display("FAIL chg_unexpected cyc=%0d got chg=1 want chg=0 (queued=%0d)", cyc, sb.size());
                end else begin
                    e = sb.pop_front();
                    if (got !== e.code) begin
                        miscompares++;
                        $display("FAIL chg_code cyc=%0d got=%b want=%b", cyc, got, e.code);
                    end
                end
            end else if (chg !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("FAIL chg_x cyc=%0d got chg=%b want 0/1", cyc, chg);
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL chg_missing cyc=%0d got chg=0 want chg=1 code=%b", cyc, sb[0].code);
                e = sb.pop_front();
            end
        end
    end

    task automatic hold(input logic [7:0] v, input int n);
        in = v;
        repeat (n) @(negedge sys_clk);
    endtask

    // Stimulus
    initial begin
        logic [7:0] cur;
        logic [7:0] one;
        int         kind;
        sys_rst_n = 1'b0;
        in        = 8'hFF;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        hold(8'hFF, 12);

        hold(8'h00, 12);
        hold(8'h10, 12);
        hold(8'h01, 2);          // short glitch, must be rejected
        hold(8'h10, 12);
        hold(8'h80, 12);
        hold(8'hC1, 12);         // same code, err rises when enabled
        hold(8'h80, 12);
        hold(8'hC0, 12);
        hold(8'h04, 12);
        hold(8'h00, 12);
        hold(8'h20, 12);

        // Reset pulse between clock edges while a new value is filtering.
        hold(8'h02, 2);
        #2 sys_rst_n = 1'b0;
        #1;
        vectors++;
        if ({valid, out, chg} !== 5'd0) begin
            miscompares++;
            $display("FAIL async_reset got {valid,out,chg}=%b want 00000", {valid, out, chg});
        end
        #1 sys_rst_n = 1'b1;
        @(negedge sys_clk);
        hold(8'h02, 12);

        cur = 8'h02;
        one = 8'h01;
        for (int k = 0; k < 250; k++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0:       cur = 8'h00;
                1:       cur = one << $urandom_range(0, 7);
                2:       cur = 8'($urandom);
                default: cur = cur ^ (one << $urandom_range(0, 7));
            endcase
            hold(cur, $urandom_range(1, 9));
        end
        hold(cur, 15);

        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending changes want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_encoder_8_3
